// File: rtl/instruction_fetch_sequencer.sv
// Purpose: owns the PC, fetches words from instruction memory by req/ack and issues them on Ins.
// Latency: Ins_Valid strobes one cycle after the acknowledging edge; LD/JMP/HLT add 1/2/halt bubbles.
// Backpressure: Mem_Req is held with a stable Mem_Addr until Mem_Ack; issue freezes in HALT until Resume.
module instruction_fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [19:0]       Mem_Data,
  input  logic              Mem_Ack,
  input  logic              Resume,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [19:0]       Ins,
  output logic              Ins_Valid,
  output logic              Halted,
  output logic [ADDR_W-1:0] PC
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_JB1   = 3'd3,
    ST_JB2   = 3'd4,
    ST_LB    = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  // Opcodes shared with the stage-clock generator; both ends must bubble identically.
  localparam logic [4:0]        OP_HLT = 5'b10001;
  localparam logic [4:0]        OP_LD  = 5'b10100;
  localparam logic [2:0]        OP_JMP = 3'b111;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [19:0]       ins_q, ins_nxt;
  logic              mem_req_q, ins_vld_q, halted_q;
  logic              is_jmp, is_ld, is_hlt;
  logic [ADDR_W-1:0] pc_inc, jmp_tgt;

  // The issued word stays in ins_q through the bubbles, so the jump target is read from it.
  assign is_jmp  = (ins_q[19:17] == OP_JMP);
  assign is_ld   = (ins_q[19:15] == OP_LD);
  assign is_hlt  = (ins_q[19:15] == OP_HLT);
  assign pc_inc  = pc_q + PC_ONE;
  assign jmp_tgt = ins_q[ADDR_W-1:0];

  // Next-state, next-PC and instruction-capture decode.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ins_nxt   = ins_q;
    case (state)
      ST_RST: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (Mem_Ack) begin
          ins_nxt   = Mem_Data;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (is_jmp) begin
          state_nxt = ST_JB1;
        end else if (is_hlt) begin
          state_nxt = ST_HALT;
        end else if (is_ld) begin
          state_nxt = ST_LB;
        end else begin
          state_nxt = ST_FETCH;
          pc_nxt    = pc_inc;
        end
      end
      ST_LB: begin
        state_nxt = ST_FETCH;
        pc_nxt    = pc_inc;
      end
      ST_JB1: begin
        state_nxt = ST_JB2;
      end
      ST_JB2: begin
        state_nxt = ST_FETCH;
        pc_nxt    = jmp_tgt;
      end
      ST_HALT: begin
        if (Resume) begin
          state_nxt = ST_FETCH;
          pc_nxt    = pc_inc;
        end
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

  // State, PC and Ins registers plus outputs registered from the next-state decode.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= ST_RST;
      pc_q      <= RESET_PC;
      ins_q     <= '0;
      mem_req_q <= 1'b0;
      ins_vld_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      ins_q     <= ins_nxt;
      mem_req_q <= (state_nxt == ST_FETCH);
      ins_vld_q <= (state_nxt == ST_ISSUE);
      halted_q  <= (state_nxt == ST_HALT);
    end
  end

  assign Mem_Req   = mem_req_q;
  assign Mem_Addr  = pc_q;
  assign PC        = pc_q;
  assign Ins       = ins_q;
  assign Ins_Valid = ins_vld_q;
  assign Halted    = halted_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: memory responder with per-address wait states,
// a program-level reference model feeding expected fetch/issue queues, and an issue monitor.
module tb_instruction_fetch_sequencer;
  localparam int            AW     = 8;
  localparam logic [AW-1:0] RST_PC = 8'h10;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [19:0]   Mem_Data;
  logic          Mem_Ack;
  logic          Resume;
  logic          Mem_Req;
  logic [AW-1:0] Mem_Addr;
  logic [19:0]   Ins;
  logic          Ins_Valid;
  logic          Halted;
  logic [AW-1:0] PC;

  instruction_fetch_sequencer #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Mem_Data(Mem_Data), .Mem_Ack(Mem_Ack), .Resume(Resume),
    .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Ins(Ins), .Ins_Valid(Ins_Valid),
    .Halted(Halted), .PC(PC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [19:0]   ins;
    logic [AW-1:0] pc;
    int            gap;   // cycles since previous Ins_Valid; 0 = not checked
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] fetch_q[$];
  logic [19:0]   mem [256];
  int            wait_tab [256];
  int            n_cmp  = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_req"},   32'(Mem_Req),   32'(1'b0));
    check({tag, "_ins_valid"}, 32'(Ins_Valid), 32'(1'b0));
    check({tag, "_halted"},    32'(Halted),    32'(1'b0));
    check({tag, "_ins"},       32'(Ins),       32'(20'h0));
    check({tag, "_pc"},        32'(PC),        32'(RST_PC));
    check({tag, "_mem_addr"},  32'(Mem_Addr),  32'(RST_PC));
  endtask

  // Reference model: walk the program as an instruction stream and list fetch addresses
  // and issued words with the issue-to-issue spacing each opcode implies.
  task automatic build_model(input int n_issue);
    logic [AW-1:0] pc;
    logic [19:0]   w;
    int            base;
    exp_t          e;
    pc   = RST_PC;
    base = 0;
    for (int i = 0; i < n_issue; i++) begin
      w = mem[pc];
      fetch_q.push_back(pc);
      e.ins = w;
      e.pc  = pc;
      e.gap = (base == 0) ? 0 : base + wait_tab[pc];
      exp_q.push_back(e);
      if (w[19:17] == 3'b111) begin
        base = 4; pc = w[AW-1:0];
      end else if (w[19:15] == 5'b10100) begin
        base = 3; pc = pc + 8'd1;
      end else if (w[19:15] == 5'b10001) begin
        base = 0; pc = pc + 8'd1;
      end else begin
        base = 2; pc = pc + 8'd1;
      end
    end
    fetch_q.push_back(pc);
  endtask

  // Serve fetches and resumes until n_issue fetches are done, then reset on the next request
  // with a coincident Mem_Ack. Entered and left on a negedge.
  task automatic run(input int n_issue, input int halt_len, input int max_cyc);
    int            fetches   = 0;
    int            wcnt      = 0;
    int            halt_wait = 0;
    int            halt_st   = 0;
    bit            in_req    = 1'b0;
    bit            done      = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [AW-1:0] exp_addr;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      if (cyc != 0) @(negedge Clk);
      Mem_Ack = 1'b0;
      Resume  = 1'b0;
      if (halt_st == 1) begin
        check("halted_high", 32'(Halted), 32'(1'b1));
        check("halt_no_req", 32'(Mem_Req), 32'(1'b0));
        if (halt_wait == 0) begin
          Resume  = 1'b1;
          halt_st = 2;
        end else begin
          halt_wait--;
        end
      end else if (halt_st == 2) begin
        check("resume_halted_low", 32'(Halted), 32'(1'b0));
        check("resume_fetch_req", 32'(Mem_Req), 32'(1'b1));
        halt_st = 0;
      end else if (Ins_Valid && Ins[19:15] == 5'b10001) begin
        // Resume during the HLT issue cycle must be ignored.
        Resume    = 1'b1;
        halt_wait = (halt_len < 0) ? int'($urandom_range(0, 6)) : halt_len;
        halt_st   = 1;
      end
      if (Mem_Req) begin
        if (!in_req) begin
          in_req   = 1'b1;
          wcnt     = 0;
          req_addr = Mem_Addr;
          if (fetch_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_fetch: addr %0h, none expected", Mem_Addr);
          end else begin
            exp_addr = fetch_q.pop_front();
            check("fetch_addr", 32'(Mem_Addr), 32'(exp_addr));
          end
          fetches++;
          if (fetches > n_issue) begin
            Mem_Ack  = 1'b1;
            Mem_Data = 20'h0_7777;
            Rst_n    = 1'b0;
            done     = 1'b1;
          end
        end else begin
          check("addr_stable", 32'(Mem_Addr), 32'(req_addr));
        end
        if (!done) begin
          if (wcnt == wait_tab[req_addr]) begin
            Mem_Ack  = 1'b1;
            Mem_Data = mem[req_addr];
            in_req   = 1'b0;
          end else begin
            wcnt++;
          end
        end
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL run_timeout: %0d of %0d fetches served", fetches, n_issue + 1);
      Rst_n   = 1'b0;
      Mem_Ack = 1'b1;
    end
  endtask

  task automatic release_and_run(input int n, input int hl, input int maxc);
    @(negedge Clk);
    Mem_Ack = 1'b0;
    Resume  = 1'b0;
    Rst_n   = 1'b1;
    check("release_no_req", 32'(Mem_Req), 32'(1'b0));
    @(negedge Clk);
    check("first_fetch_req", 32'(Mem_Req), 32'(1'b1));
    check("first_fetch_addr", 32'(Mem_Addr), 32'(RST_PC));
    run(n, hl, maxc);
  endtask

  task automatic post_reset();
    @(negedge Clk);
    Mem_Ack = 1'b0;
    check_reset("reset_mid_fetch");
    @(negedge Clk);
    check_reset("reset_settled");
    check("exp_drained", 32'(exp_q.size()), 32'(0));
    check("fetch_drained", 32'(fetch_q.size()), 32'(0));
    exp_q.delete();
    fetch_q.delete();
  endtask

  // Issue monitor: compares each Ins_Valid against the model and checks Ins holds otherwise.
  logic        rst_q = 1'b0;
  int          mon_cyc  = 0;
  int          mon_last = 0;
  logic [19:0] mon_ins  = '0;
  exp_t        mon_e;

  always @(posedge Clk) rst_q <= Rst_n;

  initial begin
    forever begin
      @(negedge Clk);
      mon_cyc++;
      if (!rst_q) begin
        mon_ins = '0;
      end else if (Ins_Valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_issue: Ins=%05h PC=%02h, none expected", Ins, PC);
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_ins", 32'(Ins), 32'(mon_e.ins));
          check("issue_pc", 32'(PC), 32'(mon_e.pc));
          if (mon_e.gap != 0) check("issue_gap", 32'(mon_cyc - mon_last), 32'(mon_e.gap));
        end
        mon_last = mon_cyc;
        mon_ins  = Ins;
      end else begin
        check("ins_hold", 32'(Ins), 32'(mon_ins));
      end
    end
  end

  // Stimulus: directed program first, then randomized programs.
  initial begin
    logic [19:0] w;
    int          k;
    Rst_n    = 1'b0;
    Mem_Ack  = 1'b1;
    Resume   = 1'b1;
    Mem_Data = 20'h8_8000;

    for (int a = 0; a < 256; a++) begin
      mem[a]      = 20'(a);
      wait_tab[a] = 0;
    end
    mem[8'h10]     = 20'hE_0000;  // JMP 0x00
    mem[8'h00]     = 20'h0_1234;
    mem[8'h01]     = 20'h0_5678;
    mem[8'h02]     = 20'h0_0002;
    mem[8'h03]     = 20'hA_0000;  // LD
    mem[8'h04]     = 20'h8_8000;  // HLT
    mem[8'h05]     = 20'hE_0042;  // JMP 0x42
    mem[8'h42]     = 20'hE_00FF;  // JMP 0xFF
    mem[8'hFF]     = 20'h0_ABCD;  // wraps to 0x00
    wait_tab[8'hFF] = 3;

    // Reset held with Mem_Ack and Resume asserted: both must be ignored.
    repeat (3) begin
      @(negedge Clk);
      check_reset("reset_hold");
    end

    build_model(10);
    release_and_run(10, 10, 400);
    post_reset();

    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 256; a++) begin
        k = int'($urandom_range(0, 9));
        w = 20'($urandom);
        case (k)
          6:       w[19:15] = 5'b10100;
          7:       w[19:17] = 3'b111;
          8:       w[19:15] = 5'b10001;
          default: if (w[19:17] == 3'b111 || w[19:15] == 5'b10100 || w[19:15] == 5'b10001) w[19] = 1'b0;
        endcase
        mem[a]      = w;
        wait_tab[a] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      build_model(120);
      release_and_run(120, -1, 3000);
      post_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
